// File: rtl/ascon_block_packer.sv
// ascon_block_packer: packs a byte stream into big-endian rate blocks for
// the ASCON-128 data phases and applies 0x80/zero padding. The final block
// is flagged, and a padding-only block follows when the message length is a
// multiple of the rate.
module ascon_block_packer #(
  parameter int unsigned RATE_BYTES = 8,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                    clock_i,
  input  logic                    reset_i,
  input  logic [7:0]              byte_i,
  input  logic                    byte_valid_i,
  input  logic                    byte_last_i,
  output logic                    byte_ready_o,
  input  logic                    empty_i,
  output logic [8*RATE_BYTES-1:0] block_o,
  output logic                    block_valid_o,
  output logic                    block_last_o,
  input  logic                    block_ready_i,
  output logic [CNT_W-1:0]        block_count_o
);

  localparam int unsigned BW    = 8 * RATE_BYTES;
  localparam int unsigned IDX_W = (RATE_BYTES > 1) ? $clog2(RATE_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(RATE_BYTES - 1);
  localparam logic [BW-1:0]    PAD_BLOCK = BW'(128) << (BW - 8);

  typedef enum logic {
    FILL,
    HOLD
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [BW-1:0]    blk_q, blk_d;
  logic             last_q, last_d;
  logic             pad_q, pad_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             byte_xfer;
  logic             blk_xfer;

  assign byte_ready_o  = (state_q == FILL);
  assign block_valid_o = (state_q == HOLD);
  assign block_o       = blk_q;
  assign block_last_o  = last_q;
  assign block_count_o = cnt_q;

  assign byte_xfer = byte_valid_i & byte_ready_o;
  assign blk_xfer  = block_valid_o & block_ready_i;

  // Next-state logic: byte insertion, padding, handoff and counting.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    blk_d   = blk_q;
    last_d  = last_q;
    pad_d   = pad_q;
    cnt_d   = cnt_q;
    case (state_q)
      FILL: begin
        if (byte_xfer) begin
          for (int unsigned i = 0; i < RATE_BYTES; i++) begin
            if (IDX_W'(i) == idx_q) blk_d[8*(RATE_BYTES-i)-1 -: 8] = byte_i;
          end
          if (idx_q == LAST_IDX) begin
            // Full block: a last byte here defers its padding to an extra block.
            state_d = HOLD;
            last_d  = 1'b0;
            pad_d   = byte_last_i;
          end else if (byte_last_i) begin
            // Trailing bytes are already zero since the buffer is cleared on handoff.
            for (int unsigned i = 0; i < RATE_BYTES; i++) begin
              if (32'(idx_q) + 32'd1 == i) blk_d[8*(RATE_BYTES-i)-1 -: 8] = 8'h80;
            end
            state_d = HOLD;
            last_d  = 1'b1;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else if (empty_i && (idx_q == '0)) begin
          blk_d   = PAD_BLOCK;
          state_d = HOLD;
          last_d  = 1'b1;
        end
      end
      HOLD: begin
        if (blk_xfer) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (pad_q) begin
            blk_d  = PAD_BLOCK;
            last_d = 1'b1;
            pad_d  = 1'b0;
          end else begin
            state_d = FILL;
            idx_d   = '0;
            blk_d   = '0;
            last_d  = 1'b0;
          end
        end
      end
      default: state_d = FILL;
    endcase
  end

  // State register with synchronous active-high reset.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= FILL;
      idx_q   <= '0;
      blk_q   <= '0;
      last_q  <= 1'b0;
      pad_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      blk_q   <= blk_d;
      last_q  <= last_d;
      pad_q   <= pad_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_ascon_block_packer.sv
// Self-checking bench for ascon_block_packer: a message-level model (queue of
// padded blocks awaiting handoff) is compared against the DUT every cycle,
// with directed literal expectations plus randomized traffic.
module tb_ascon_block_packer;

  localparam int unsigned R     = 8;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned BW    = 8 * R;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [7:0]       b_data = '0;
  logic             b_valid = 1'b0;
  logic             b_last = 1'b0;
  logic             b_ready;
  logic             emp = 1'b0;
  logic [BW-1:0]    blk;
  logic             blk_valid;
  logic             blk_last;
  logic             blk_ready = 1'b0;
  logic [CNT_W-1:0] cnt;

  always #5 clk = ~clk;

  ascon_block_packer #(.RATE_BYTES(R), .CNT_W(CNT_W)) dut (
    .clock_i(clk), .reset_i(rst), .byte_i(b_data), .byte_valid_i(b_valid),
    .byte_last_i(b_last), .byte_ready_o(b_ready), .empty_i(emp),
    .block_o(blk), .block_valid_o(blk_valid), .block_last_o(blk_last),
    .block_ready_i(blk_ready), .block_count_o(cnt)
  );

  int unsigned passed = 0;
  int unsigned total  = 0;

  // Model: blocks waiting for handoff, bytes of the block being gathered.
  logic [BW-1:0] mq_blk[$];
  bit            mq_last[$];
  logic [7:0]    cur[$];
  int unsigned   m_cnt = 0;
  bit            model_on = 0;
  bit            last_acc;
  logic [BW-1:0] mlog_blk[$];
  bit            mlog_last[$];
  logic [BW-1:0] dlog_blk[$];
  bit            dlog_last[$];

  task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [BW-1:0] pack(input bit pad);
    logic [BW-1:0] v;
    logic [7:0]    b;
    v = '0;
    for (int i = 0; i < R; i++) begin
      if (i < cur.size()) b = cur[i];
      else if (pad && i == cur.size()) b = 8'h80;
      else b = 8'h00;
      v = {v[BW-9:0], b};
    end
    return v;
  endfunction

  task automatic model_step(input bit r, input bit bv, input bit bl, input logic [7:0] bd,
                            input bit e, input bit br);
    last_acc = 0;
    if (r) begin
      mq_blk.delete(); mq_last.delete(); cur.delete(); m_cnt = 0;
      return;
    end
    if (mq_blk.size() > 0) begin
      if (br) begin
        mlog_blk.push_back(mq_blk.pop_front());
        mlog_last.push_back(mq_last.pop_front());
        m_cnt = (m_cnt + 1) % (1 << CNT_W);
      end
    end else if (bv) begin
      last_acc = 1;
      cur.push_back(bd);
      if (cur.size() == R) begin
        mq_blk.push_back(pack(0)); mq_last.push_back(0);
        cur.delete();
        if (bl) begin mq_blk.push_back(pack(1)); mq_last.push_back(1); end
      end else if (bl) begin
        mq_blk.push_back(pack(1)); mq_last.push_back(1);
        cur.delete();
      end
    end else if (e && cur.size() == 0) begin
      last_acc = 1;
      mq_blk.push_back(pack(1)); mq_last.push_back(1);
    end
  endtask

  // One clock: drive, let the edge happen, advance the model, settle.
  task automatic cyc(input bit bv, input bit bl, input logic [7:0] bd, input bit e,
                     input bit br, input bit r);
    b_valid = bv; b_last = bl; b_data = bd; emp = e; blk_ready = br; rst = r;
    @(posedge clk);
    model_step(r, bv, bl, bd, e, br);
    #1;
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (model_on) begin
      chk("block_valid", BW'(blk_valid), BW'(mq_blk.size() > 0));
      chk("byte_ready", BW'(b_ready), BW'(mq_blk.size() == 0));
      chk("block_count", BW'(cnt), BW'(m_cnt));
      if (mq_blk.size() > 0) begin
        chk("block", blk, mq_blk[0]);
        chk("block_last", BW'(blk_last), BW'(mq_last[0]));
        if (blk_ready) begin dlog_blk.push_back(blk); dlog_last.push_back(blk_last); end
      end
    end
  end

  task automatic clear_logs();
    mlog_blk.delete(); mlog_last.delete(); dlog_blk.delete(); dlog_last.delete();
  endtask

  task automatic do_reset();
    cyc(0, 0, 8'h00, 0, 0, 1);
    model_on = 1;
    cyc(0, 0, 8'h00, 0, 0, 1);
    clear_logs();
  endtask

  task automatic send(input logic [7:0] bs[$], input bit lastflag, input bit br);
    for (int i = 0; i < bs.size(); i++) begin
      int n;
      n = 0;
      do begin
        cyc(1, lastflag && (i == bs.size() - 1), bs[i], 0, br, 0);
        n++;
      end while (!last_acc && n < 100);
      if (!last_acc) chk("send_timeout", BW'(b_ready), BW'(1));
    end
  endtask

  task automatic drain();
    for (int n = 0; n < 50 && mq_blk.size() > 0; n++) cyc(0, 0, 8'h00, 0, 1, 0);
    chk("drain_idle", BW'(blk_valid), BW'(0));
  endtask

  task automatic expect_n(input string name, input int unsigned n);
    chk({name, "_n_model"}, BW'(mlog_blk.size()), BW'(n));
    chk({name, "_n_dut"}, BW'(dlog_blk.size()), BW'(n));
  endtask

  task automatic expect_blk(input string name, input int unsigned i,
                            input logic [BW-1:0] v, input bit l);
    if (i < mlog_blk.size()) begin
      chk({name, "_model"}, mlog_blk[i], v);
      chk({name, "_model_last"}, BW'(mlog_last[i]), BW'(l));
    end
    if (i < dlog_blk.size()) begin
      chk({name, "_dut"}, dlog_blk[i], v);
      chk({name, "_dut_last"}, BW'(dlog_last[i]), BW'(l));
    end
  endtask

  initial begin
    logic [7:0] q[$];
    int unsigned rem;
    logic [7:0] hold_b;
    bit emp_msg;

    // Reset state
    do_reset();
    chk("rst_valid", BW'(blk_valid), BW'(0));
    chk("rst_block", blk, 64'h0);
    chk("rst_last", BW'(blk_last), BW'(0));
    chk("rst_count", BW'(cnt), BW'(0));
    chk("rst_ready", BW'(b_ready), BW'(1));

    // Short message: 3 bytes
    q = '{8'h01, 8'h02, 8'h03};
    send(q, 1, 1);
    chk("t1_latency_valid", BW'(blk_valid), BW'(1));
    drain();
    expect_n("t1", 1);
    expect_blk("t1_b0", 0, 64'h0102038000000000, 1);
    chk("t1_count", BW'(cnt), BW'(1));

    // Exact-rate message: extra padding block
    do_reset();
    q = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
    send(q, 1, 1);
    chk("t2_hold1_ready", BW'(b_ready), BW'(0));
    cyc(0, 0, 8'h00, 0, 1, 0);
    chk("t2_hold2_ready", BW'(b_ready), BW'(0));
    chk("t2_hold2_block", blk, 64'h8000000000000000);
    cyc(0, 0, 8'h00, 0, 1, 0);
    chk("t2_fill_ready", BW'(b_ready), BW'(1));
    expect_n("t2", 2);
    expect_blk("t2_b0", 0, 64'h0001020304050607, 0);
    expect_blk("t2_b1", 1, 64'h8000000000000000, 1);
    chk("t2_count", BW'(cnt), BW'(2));

    // Backpressure with 10-byte message
    do_reset();
    q = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
    send(q, 0, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(1, 0, 8'h08, 0, 0, 0);
      chk("t3_stable_block", blk, 64'h0001020304050607);
      chk("t3_stable_ready", BW'(b_ready), BW'(0));
    end
    cyc(0, 0, 8'h00, 0, 1, 0);
    q = '{8'h08, 8'h09};
    send(q, 1, 1);
    drain();
    expect_n("t3", 2);
    expect_blk("t3_b0", 0, 64'h0001020304050607, 0);
    expect_blk("t3_b1", 1, 64'h0809800000000000, 1);

    // Empty message, then ignored empty_i mid-message
    do_reset();
    cyc(0, 0, 8'h00, 1, 0, 0);
    drain();
    q = '{8'hA0, 8'hA1};
    send(q, 0, 1);
    cyc(0, 0, 8'h00, 1, 1, 0);
    chk("t4_ignored_empty", BW'(blk_valid), BW'(0));
    q = '{8'hA2};
    send(q, 1, 1);
    drain();
    expect_n("t4", 2);
    expect_blk("t4_b0", 0, 64'h8000000000000000, 1);
    expect_blk("t4_b1", 1, 64'hA0A1A28000000000, 1);

    // Reset mid-message
    do_reset();
    q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    send(q, 0, 1);
    cyc(0, 0, 8'h00, 0, 1, 1);
    chk("t5_valid", BW'(blk_valid), BW'(0));
    chk("t5_count", BW'(cnt), BW'(0));
    cyc(0, 0, 8'h00, 0, 1, 0);
    chk("t5_ready", BW'(b_ready), BW'(1));
    clear_logs();
    q = '{8'hAA};
    send(q, 1, 1);
    drain();
    expect_n("t5", 1);
    expect_blk("t5_b0", 0, 64'hAA80000000000000, 1);

    // Counter wrap
    do_reset();
    for (int i = 0; i < (1 << CNT_W) - 1; i++) begin
      cyc(0, 0, 8'h00, 1, 0, 0);
      cyc(0, 0, 8'h00, 0, 1, 0);
    end
    chk("t6_count_max", BW'(cnt), BW'((1 << CNT_W) - 1));
    cyc(0, 0, 8'h00, 1, 0, 0);
    cyc(0, 0, 8'h00, 0, 1, 0);
    chk("t6_count_wrap", BW'(cnt), BW'(0));

    // Randomized traffic with occasional spurious empty_i and resets
    do_reset();
    rem = 0; emp_msg = 0; hold_b = $urandom_range(0, 255);
    for (int c = 0; c < 6000; c++) begin
      bit bv, e, br, r;
      if (rem == 0 && !emp_msg) begin
        rem = $urandom_range(0, 20);
        if (rem == 0) emp_msg = 1;
      end
      r  = ($urandom_range(0, 299) == 0);
      br = ($urandom_range(0, 2) != 0);
      bv = (rem > 0) && ($urandom_range(0, 3) != 0);
      e  = emp_msg || ($urandom_range(0, 9) == 0);
      cyc(bv, bv && rem == 1, hold_b, e, br, r);
      if (last_acc && bv) begin
        rem--;
        hold_b = $urandom_range(0, 255);
      end else if (last_acc && emp_msg) begin
        emp_msg = 0;
      end
    end
    drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
